// File: rtl/mbist_addr_gen.sv
// MBIST address generator: sweeps a test address range up or down, one step per
// completed march element, with scan access to the counter and error-correction rewind.
module mbist_addr_gen #(
  parameter int unsigned                 BIST_ADDR_WD    = 9,
  parameter logic [BIST_ADDR_WD-1:0]     BIST_ADDR_START = 9'h000,
  parameter logic [BIST_ADDR_WD-1:0]     BIST_ADDR_END   = 9'h1F8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_shift,
  input  logic                    sdi,
  input  logic                    re_init,
  input  logic                    run,
  input  logic                    last_op,
  input  logic                    op_updown,
  input  logic                    op_reverse,
  output logic [BIST_ADDR_WD-1:0] bist_addr,
  output logic                    addr_valid,
  output logic                    last_addr,
  output logic                    addr_wrap,
  output logic                    sdo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_e;

  localparam logic [BIST_ADDR_WD-1:0] ONE = BIST_ADDR_WD'(1);

  state_e                  state, state_nxt;
  logic [BIST_ADDR_WD-1:0] addr_cnt, cnt_nxt;
  logic [BIST_ADDR_WD-1:0] term;
  logic [BIST_ADDR_WD-1:0] addr_rev;
  logic                    at_term;
  logic                    in_sweep;
  logic                    step_go;

  // Terminal address follows op_updown live, so a mid-sweep direction flip retargets at once.
  assign term     = op_updown ? BIST_ADDR_END : BIST_ADDR_START;
  assign at_term  = (addr_cnt == term);
  assign in_sweep = (state == SWEEP);
  assign step_go  = in_sweep && run && last_op && !re_init && !scan_shift;
  assign sdo      = addr_cnt[0];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking here so every register samples pre-edge values regardless of order.
    if (!rst_n) begin
      state    <= IDLE;
      addr_cnt <= BIST_ADDR_START;
    end else begin
      state    <= state_nxt;
      addr_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case can infer a latch.
    state_nxt = state;
    cnt_nxt   = addr_cnt;
    if (scan_shift) begin
      cnt_nxt = {sdi, addr_cnt[BIST_ADDR_WD-1:1]};
    end else if (!re_init) begin
      unique case (state)
        IDLE: begin
          if (run) state_nxt = LOAD;
        end
        LOAD: begin
          cnt_nxt   = op_updown ? BIST_ADDR_START : BIST_ADDR_END;
          state_nxt = SWEEP;
        end
        SWEEP: begin
          if (run && last_op) begin
            if (at_term) state_nxt = LOAD;
            else         cnt_nxt   = op_updown ? addr_cnt + ONE : addr_cnt - ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < int'(BIST_ADDR_WD); i++) begin
      addr_rev[i] = addr_cnt[int'(BIST_ADDR_WD) - 1 - i];
    end
    bist_addr  = op_reverse ? addr_rev : addr_cnt;
    addr_valid = in_sweep;
    last_addr  = in_sweep && at_term;
    addr_wrap  = step_go && at_term;
  end

endmodule

// File: doc/mbist_addr_gen.md
MBIST_ADDR_GEN -- requirements
Module: mbist_addr_gen

Interface
REQ-001 Parameter BIST_ADDR_WD, default 9: address width.
REQ-002 Parameter BIST_ADDR_START, default 9'h000: lowest test address.
REQ-003 Parameter BIST_ADDR_END, default 9'h1F8: highest test address; SHALL be greater than BIST_ADDR_START.
REQ-004 Port list, one per line:
- clk, input, 1: clock. The block SHALL use one clock.
- rst_n, input, 1: reset. Reset SHALL be synchronous and active-low.
- scan_shift, input, 1: scan shift enable.
- sdi, input, 1: scan data in.
- re_init, input, 1: error-correction rewind; holds the address.
- run, input, 1: BIST run enable.
- last_op, input, 1: final operation of the current march element at this address, from the operation selector.
- op_updown, input, 1: 1 = ascending sweep, 0 = descending sweep.
- op_reverse, input, 1: 1 = drive the bit-reversed address.
- bist_addr, output, BIST_ADDR_WD: memory address.
- addr_valid, output, 1: bist_addr is a live test address.
- last_addr, output, 1: current address is the terminal address of the sweep.
- addr_wrap, output, 1: one-cycle pulse marking sweep completion.
- sdo, output, 1: scan data out.

Function
REQ-005 The block SHALL hold an internal counter addr_cnt[BIST_ADDR_WD-1:0] and a state machine with states IDLE, LOAD and SWEEP.
REQ-006 Priority per cycle SHALL be: reset, then scan_shift, then re_init, then run.
REQ-007 scan_shift=1 SHALL set addr_cnt <= {sdi, addr_cnt[WD-1:1]}. The state SHALL be unchanged and addr_wrap SHALL be 0.
REQ-008 sdo SHALL equal addr_cnt[0] combinationally.
REQ-009 IDLE: run=1 SHALL move the FSM to LOAD. Otherwise it stays in IDLE.
REQ-010 LOAD: addr_cnt SHALL be loaded with op_updown ? BIST_ADDR_START : BIST_ADDR_END and the FSM SHALL move to SWEEP. LOAD lasts exactly 1 cycle and ignores run.
REQ-011 The terminal address is term = op_updown ? BIST_ADDR_END : BIST_ADDR_START, evaluated each cycle.
REQ-012 SWEEP with run=1, last_op=1 and addr_cnt != term: addr_cnt SHALL step by +1 when op_updown=1 and by -1 when op_updown=0.
REQ-013 SWEEP with run=1, last_op=1 and addr_cnt == term: addr_wrap SHALL be 1 in that cycle (combinational) and the FSM SHALL go to LOAD. addr_cnt is unchanged in that cycle.
REQ-014 SWEEP with run=1 and last_op=0: hold.
REQ-015 SWEEP with run=0: hold addr_cnt and state; no return to IDLE.
REQ-016 re_init=1 (scan_shift=0) SHALL hold addr_cnt and state and force addr_wrap=0, regardless of run and last_op.
REQ-017 bist_addr SHALL be op_reverse ? bit-reverse(addr_cnt) : addr_cnt, combinationally.
REQ-018 addr_valid SHALL be 1 only in SWEEP.
REQ-019 last_addr SHALL be (state==SWEEP) && (addr_cnt==term).
REQ-020 addr_wrap SHALL be (state==SWEEP) && run && last_op && !re_init && !scan_shift && (addr_cnt==term).
REQ-021 Arithmetic SHALL be BIST_ADDR_WD bits wide. The counter never leaves [START, END] in functional mode. A value outside that range loaded by scan SHALL still step by ±1 modulo 2^WD until it reaches term.
REQ-022 op_updown changing mid-sweep SHALL take effect immediately for both step direction and term; no error flag is raised.

Reset
REQ-023 When rst_n=0 at a clk edge, the block SHALL set state=IDLE and addr_cnt=BIST_ADDR_START.
REQ-024 Outputs after reset SHALL be: bist_addr=START (or its bit-reversal when op_reverse=1), addr_valid=0, last_addr=0, addr_wrap=0, sdo=START[0].
REQ-025 Reset asserted mid-sweep SHALL abandon the sweep with no addr_wrap pulse.
REQ-026 rst_n SHALL have no asynchronous effect.

Verification
REQ-027 Ascending sweep: defaults, op_updown=1, run=1, last_op=1 constant. Required response:
- addr_valid rises 2 cycles after run.
- bist_addr goes 000, 001, ... 1F8.
- last_addr=1 at 1F8 only.
- addr_wrap pulses 1 cycle at 1F8.
- LOAD reloads 000.
REQ-028 Descending sweep: op_updown=0. Required response: sweep 1F8 down to 000, addr_wrap at 000, then reload 1F8.
REQ-029 last_op pattern 0,0,1 repeating with op_updown=1. Required response: address advances once every 3 cycles, 000, 000, 000, 001, ...
REQ-030 At addr_cnt=005 assert re_init for 2 cycles with last_op=1. Required response: address holds at 005 with no step; stepping resumes to 006 after release.
REQ-031 Assert scan_shift for 9 cycles with sdi pattern 1,0,1,0,1,0,1,0,1 (LSB first) from addr_cnt=000. Required response: addr_cnt=155, and sdo emits the original bits 0 x9.
REQ-032 op_reverse=1 at addr_cnt=001. Required response: bist_addr=100. Then assert rst_n=0 mid-sweep: IDLE, addr_valid=0, no addr_wrap.
